// File: rtl/sys_ctrl.sv
// UART-command system controller: decodes framed RX bytes into RF writes/reads and ALU
// operations, and returns results to the TX FIFO. Optional frame timeout: SYS_CTRL_TIMEOUT_EN.
module sys_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   UART_RX_DATA,
  input  logic                    UART_RX_VLD,
  input  logic                    FIFO_FULL,
  input  logic                    RF_RdData_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic                    CLKG_EN,
  output logic                    CLKDIV_EN,
  output logic                    ALU_EN,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic [DATA_WIDTH-1:0]   UART_TX_DATA,
  output logic                    UART_TX_VLD
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = 'hAA;
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = 'hBB;
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = 'hCC;
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_FUN = 'hDD;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT,
    S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT,
    S_TX_RD, S_TX_LSB, S_TX_MSB
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [2*DATA_WIDTH-1:0] tx_hold;
  logic                    timed_out;

  // The divider runs whenever the block is out of reset.
  assign CLKDIV_EN = RST;

`ifdef SYS_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             in_frame;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      idle_cnt <= '0;
    end else if (UART_RX_VLD) begin
      idle_cnt <= '0;
    end else if (idle_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // Only states that are waiting for another command byte can be abandoned.
  assign in_frame  = (state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_ALU_A, S_ALU_B, S_ALU_FUN});
  assign timed_out = in_frame && !UART_RX_VLD && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= S_IDLE;
      wr_addr      <= '0;
      tx_hold      <= '0;
      RF_WrEn      <= 1'b0;
      RF_RdEn      <= 1'b0;
      CLKG_EN      <= 1'b0;
      ALU_EN       <= 1'b0;
      RF_Address   <= '0;
      RF_WrData    <= '0;
      ALU_FUN      <= '0;
      UART_TX_DATA <= '0;
      UART_TX_VLD  <= 1'b0;
    end else begin
      RF_WrEn     <= 1'b0;
      UART_TX_VLD <= 1'b0;
      if (timed_out) begin
        state   <= S_IDLE;
        CLKG_EN <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (UART_RX_VLD) begin
              case (UART_RX_DATA)
                CMD_WR:      state <= S_WR_ADDR;
                CMD_RD:      state <= S_RD_ADDR;
                CMD_ALU_OP:  state <= S_ALU_A;
                CMD_ALU_FUN: begin
                  state   <= S_ALU_FUN;
                  CLKG_EN <= 1'b1;
                end
                default:     state <= S_IDLE;
              endcase
            end
          end
          S_WR_ADDR: begin
            if (UART_RX_VLD) begin
              wr_addr <= UART_RX_DATA[ADDR_WIDTH-1:0];
              state   <= S_WR_DATA;
            end
          end
          S_WR_DATA: begin
            if (UART_RX_VLD) begin
              RF_WrEn    <= 1'b1;
              RF_Address <= wr_addr;
              RF_WrData  <= UART_RX_DATA;
              state      <= S_IDLE;
            end
          end
          S_RD_ADDR: begin
            if (UART_RX_VLD) begin
              RF_Address <= UART_RX_DATA[ADDR_WIDTH-1:0];
              RF_RdEn    <= 1'b1;
              state      <= S_RD_WAIT;
            end
          end
          S_RD_WAIT: begin
            if (RF_RdData_VLD) begin
              tx_hold <= {{DATA_WIDTH{1'b0}}, RF_RdData};
              RF_RdEn <= 1'b0;
              state   <= S_TX_RD;
            end
          end
          S_ALU_A: begin
            if (UART_RX_VLD) begin
              RF_WrEn    <= 1'b1;
              RF_Address <= ADDR_WIDTH'(0);
              RF_WrData  <= UART_RX_DATA;
              state      <= S_ALU_B;
            end
          end
          S_ALU_B: begin
            if (UART_RX_VLD) begin
              RF_WrEn    <= 1'b1;
              RF_Address <= ADDR_WIDTH'(1);
              RF_WrData  <= UART_RX_DATA;
              CLKG_EN    <= 1'b1;
              state      <= S_ALU_FUN;
            end
          end
          S_ALU_FUN: begin
            if (UART_RX_VLD) begin
              ALU_FUN <= UART_RX_DATA[FUN_WIDTH-1:0];
              ALU_EN  <= 1'b1;
              state   <= S_ALU_WAIT;
            end
          end
          S_ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
              tx_hold <= ALU_OUT;
              ALU_EN  <= 1'b0;
              CLKG_EN <= 1'b0;
              state   <= S_TX_LSB;
            end
          end
          // TX data is reloaded every cycle so it is already correct when the strobe rises.
          S_TX_RD, S_TX_LSB: begin
            UART_TX_DATA <= tx_hold[DATA_WIDTH-1:0];
            if (!FIFO_FULL) begin
              UART_TX_VLD <= 1'b1;
              state       <= (state == S_TX_RD) ? S_IDLE : S_TX_MSB;
            end
          end
          S_TX_MSB: begin
            UART_TX_DATA <= tx_hold[2*DATA_WIDTH-1:DATA_WIDTH];
            if (!FIFO_FULL) begin
              UART_TX_VLD <= 1'b1;
              state       <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_ctrl.sv
// Randomized self-checking bench for sys_ctrl; expected RF writes and TX bytes are
// derived per command frame into queues and compared against what the monitor observes.
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  UART_RX_DATA = '0;
  logic        UART_RX_VLD = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        RF_RdData_VLD = 1'b0;
  logic [7:0]  RF_RdData = '0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        RF_WrEn, RF_RdEn, CLKG_EN, CLKDIV_EN, ALU_EN, UART_TX_VLD;
  logic [3:0]  RF_Address, ALU_FUN;
  logic [7:0]  RF_WrData, UART_TX_DATA;

  int total = 0;
  int bad   = 0;

  logic [11:0] wr_obs[$];
  logic [11:0] wr_exp[$];
  logic [7:0]  tx_obs[$];
  logic [7:0]  tx_exp[$];

  sys_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RST(RST),
    .UART_RX_DATA(UART_RX_DATA), .UART_RX_VLD(UART_RX_VLD),
    .FIFO_FULL(FIFO_FULL),
    .RF_RdData_VLD(RF_RdData_VLD), .RF_RdData(RF_RdData),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .CLKG_EN(CLKG_EN), .CLKDIV_EN(CLKDIV_EN),
    .ALU_EN(ALU_EN), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
    .ALU_FUN(ALU_FUN), .UART_TX_DATA(UART_TX_DATA), .UART_TX_VLD(UART_TX_VLD)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Inputs only change on negedges, so one step after posedge they equal what the DUT sampled.
  always @(posedge CLK) begin
    #1;
    if (RST) begin
      if (RF_WrEn) wr_obs.push_back({RF_Address, RF_WrData});
      if (UART_TX_VLD) begin
        tx_obs.push_back(UART_TX_DATA);
        checkOutput("txWhileFull", 32'(FIFO_FULL), 32'd0);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge CLK);
    UART_RX_DATA = b;
    UART_RX_VLD  = 1'b1;
    @(negedge CLK);
    UART_RX_VLD  = 1'b0;
    UART_RX_DATA = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(negedge CLK);
  endtask

  task automatic drainCheck(input string tag);
    int n;
    n = 0;
    while (tx_obs.size() < tx_exp.size() && n < 200) begin
      @(negedge CLK);
      n++;
    end
    repeat (3) @(negedge CLK);
    checkOutput({tag, " wrCount"}, 32'(wr_obs.size()), 32'(wr_exp.size()));
    for (int i = 0; i < wr_exp.size() && i < wr_obs.size(); i++)
      checkOutput({tag, " wrAddrData"}, 32'(wr_obs[i]), 32'(wr_exp[i]));
    checkOutput({tag, " txCount"}, 32'(tx_obs.size()), 32'(tx_exp.size()));
    for (int i = 0; i < tx_exp.size() && i < tx_obs.size(); i++)
      checkOutput({tag, " txByte"}, 32'(tx_obs[i]), 32'(tx_exp[i]));
    wr_obs.delete(); wr_exp.delete(); tx_obs.delete(); tx_exp.delete();
  endtask

  task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(8'hAA);
    applyStimulus(a);
    applyStimulus(d);
    wr_exp.push_back({a[3:0], d});
    drainCheck("write");
  endtask

  task automatic holdFull(input int k);
    if (k > 0) begin
      repeat (k) @(negedge CLK);
      checkOutput("noTxWhileFull", 32'(tx_obs.size()), 32'd0);
      FIFO_FULL = 1'b0;
    end
  endtask

  task automatic doRead(input logic [7:0] a, input logic [7:0] d, input int k, input bit drop);
    int n;
    applyStimulus(8'hBB);
    applyStimulus(a);
    n = 0;
    while (!RF_RdEn && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("rdEnHigh", 32'(RF_RdEn), 32'd1);
    checkOutput("rdAddr", 32'(RF_Address), 32'(a[3:0]));
    if (drop) applyStimulus(8'($urandom));
    FIFO_FULL     = (k > 0);
    RF_RdData     = d;
    RF_RdData_VLD = 1'b1;
    @(negedge CLK);
    RF_RdData_VLD = 1'b0;
    checkOutput("rdEnDrop", 32'(RF_RdEn), 32'd0);
    tx_exp.push_back(d);
    holdFull(k);
    drainCheck("read");
  endtask

  task automatic doAlu(input bit cc, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] f, input logic [15:0] r, input int k, input bit drop);
    int n;
    if (cc) begin
      applyStimulus(8'hCC);
      applyStimulus(x);
      applyStimulus(y);
      wr_exp.push_back({4'h0, x});
      wr_exp.push_back({4'h1, y});
    end else begin
      applyStimulus(8'hDD);
    end
    checkOutput("clkgOnEntry", 32'(CLKG_EN), 32'd1);
    applyStimulus(f);
    n = 0;
    while (!ALU_EN && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("aluEnHigh", 32'(ALU_EN), 32'd1);
    checkOutput("aluFun", 32'(ALU_FUN), 32'(f[3:0]));
    checkOutput("clkgHeld", 32'(CLKG_EN), 32'd1);
    if (drop) begin
      applyStimulus(8'($urandom));
      checkOutput("aluEnStays", 32'(ALU_EN), 32'd1);
    end
    FIFO_FULL   = (k > 0);
    ALU_OUT     = r;
    ALU_OUT_VLD = 1'b1;
    @(negedge CLK);
    ALU_OUT_VLD = 1'b0;
    checkOutput("aluEnDrop", 32'(ALU_EN), 32'd0);
    checkOutput("clkgDrop", 32'(CLKG_EN), 32'd0);
    tx_exp.push_back(r[7:0]);
    tx_exp.push_back(r[15:8]);
    holdFull(k);
    drainCheck(cc ? "aluCC" : "aluDD");
  endtask

  initial begin
    logic [7:0] b;
    logic [29:0] outs;

    repeat (3) @(negedge CLK);
    outs = {RF_WrEn, RF_RdEn, CLKG_EN, CLKDIV_EN, ALU_EN, RF_Address, RF_WrData,
            ALU_FUN, UART_TX_DATA, UART_TX_VLD};
    checkOutput("resetOutputs", 32'(outs), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("clkdivEn", 32'(CLKDIV_EN), 32'd1);

    doWrite(8'h0C, 8'h14);
    doRead(8'h0C, 8'h14, 0, 1'b0);
    doAlu(1'b1, 8'h05, 8'h03, 8'h00, 16'h1234, 0, 1'b0);
    doAlu(1'b0, 8'h00, 8'h00, 8'h02, 16'hBEEF, 5, 1'b0);

    applyStimulus(8'h55);
    drainCheck("junk55");

    // Abandon a write frame with reset after its address byte.
    applyStimulus(8'hAA);
    applyStimulus(8'h03);
    RST = 1'b0;
    #1;
    outs = {RF_WrEn, RF_RdEn, CLKG_EN, CLKDIV_EN, ALU_EN, RF_Address, RF_WrData,
            ALU_FUN, UART_TX_DATA, UART_TX_VLD};
    checkOutput("midFrameReset", 32'(outs), 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    doWrite(8'h01, 8'hFF);

    // With the timeout the stale AA frame is dropped; without it the second AA is taken as the address.
    applyStimulus(8'hAA);
    repeat (20) @(negedge CLK);
    applyStimulus(8'hAA);
    applyStimulus(8'h02);
    applyStimulus(8'h07);
`ifdef SYS_CTRL_TIMEOUT_EN
    wr_exp.push_back({4'h2, 8'h07});
`else
    wr_exp.push_back({4'hA, 8'h02});
`endif
    drainCheck("timeout");

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 4))
        0: doWrite(8'($urandom), 8'($urandom));
        1: doRead(8'($urandom), 8'($urandom), $urandom_range(0, 1) * $urandom_range(1, 6),
                  1'($urandom_range(0, 1)));
        2: doAlu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                 $urandom_range(0, 1) * $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        3: doAlu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom),
                 $urandom_range(0, 1) * $urandom_range(1, 6), 1'($urandom_range(0, 1)));
        default: begin
          b = 8'($urandom);
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
          applyStimulus(b);
          drainCheck("junkRand");
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: got=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
